// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter for a character-cell display.
// Video fetches own fixed slots, one every 8 pixels plus one near end of line.
// CPU writes are queued in a small FIFO and drain in any cycle without a slot.
// Optional macro FB_READBACK_EN adds a CPU read port, serviced only when the
// FIFO is empty and no slot is due.
// Slot decisions are made one pixel early (PIXEL_X+1), so that the memory
// outputs are registered and still land in the slot cycle itself.
module fb_arbiter #(
  parameter int COLS       = 100,
  parameter int ROWS       = 75,
  parameter int H_TOTAL    = 1040,
  parameter int V_TOTAL    = 666,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK_PIXEL,
  input  logic        RESET_N,
  input  logic [10:0] PIXEL_X,
  input  logic [10:0] PIXEL_Y,
  input  logic        ON_SCREEN,
  input  logic        CPU_WR_VALID,
  output logic        CPU_WR_READY,
  input  logic [12:0] CPU_WR_ADDR,
  input  logic [1:0]  CPU_WR_DATA,
  output logic [12:0] FB_ADDR,
  output logic        FB_WE,
  output logic [1:0]  FB_WDATA,
  input  logic [1:0]  FB_RDATA,
  output logic [1:0]  CELL_INDEX,
  output logic        CELL_VALID,
  output logic        WR_ERR
`ifdef FB_READBACK_EN
  ,
  input  logic        CPU_RD_VALID,
  input  logic [12:0] CPU_RD_ADDR,
  output logic [1:0]  CPU_RD_DATA,
  output logic        CPU_RD_DONE
`endif
);

  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

`ifdef FB_READBACK_EN
  typedef enum logic [1:0] {IDLE, VFETCH, CWRITE, CREAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, VFETCH, CWRITE} state_t;
`endif

  state_t      state;
  logic [14:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        ready_en;
  logic        fetch_d;

  // active-video flag carries no information the pixel counters lack
  logic unused_on_screen;
  assign unused_on_screen = ON_SCREEN;

  // ---------------- FIFO status ----------------
  logic        empty, full, push, wr_oor;
  logic [14:0] head;
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign CPU_WR_READY = ready_en && !full;
  assign push   = CPU_WR_VALID && CPU_WR_READY;
  assign wr_oor = (CPU_WR_ADDR >= 13'(CELLS));
  assign head   = fifo_mem[rptr[AW-1:0]];

  // ---------------- slot lookahead ----------------
  logic [10:0] nx, ny;
  logic [11:0] ncol, fcol;
  logic [7:0]  frow;
  logic        eol_slot, col_slot, fetch_next, load_pt;
  logic [12:0] fetch_addr;

  // classify the next pixel: column slot, end-of-line slot, or neither
  always_comb begin
    nx         = PIXEL_X + 11'd1;
    ny         = (PIXEL_Y == 11'(V_TOTAL - 1)) ? 11'd0 : PIXEL_Y + 11'd1;
    ncol       = (12'(nx) + 12'd2) >> 3;
    eol_slot   = (nx == 11'(H_TOTAL - 2));
    col_slot   = (nx[2:0] == 3'd6) && (32'(ncol) < COLS);
    frow       = eol_slot ? ny[10:3] : PIXEL_Y[10:3];
    fcol       = eol_slot ? 12'd0 : ncol;
    fetch_next = (eol_slot || col_slot) && (32'(frow) < ROWS);
    fetch_addr = 13'(32'(frow) * COLS + 32'(fcol));
    load_pt    = (PIXEL_X[2:0] == 3'd7) || (PIXEL_X == 11'(H_TOTAL - 1));
  end

`ifdef FB_READBACK_EN
  logic        rd_pend, rd_oor_q, rd_d, rd_oor;
  logic [12:0] rd_addr_q;
  assign rd_oor = (rd_addr_q >= 13'(CELLS));
`endif

  // FIFO storage; out-of-range writes never occupy an entry
  always_ff @(posedge CLK_PIXEL) begin
    if (push && !wr_oor) fifo_mem[wptr[AW-1:0]] <= {CPU_WR_ADDR, CPU_WR_DATA};
  end

  // arbiter FSM: video slot first, then queued writes, then reads
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      FB_ADDR  <= '0;
      FB_WE    <= 1'b0;
      FB_WDATA <= '0;
      wptr     <= '0;
      rptr     <= '0;
      ready_en <= 1'b0;
      WR_ERR   <= 1'b0;
`ifdef FB_READBACK_EN
      rd_pend   <= 1'b0;
      rd_addr_q <= '0;
      rd_oor_q  <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        if (wr_oor) WR_ERR <= 1'b1;
        else        wptr   <= wptr + PTR_ONE;
      end
      if (fetch_next) begin
        state   <= VFETCH;
        FB_WE   <= 1'b0;
        FB_ADDR <= fetch_addr;
      end else if (!empty) begin
        state    <= CWRITE;
        FB_WE    <= 1'b1;
        FB_ADDR  <= head[14:2];
        FB_WDATA <= head[1:0];
        rptr     <= rptr + PTR_ONE;
      end
`ifdef FB_READBACK_EN
      else if (rd_pend) begin
        state    <= CREAD;
        FB_WE    <= 1'b0;
        FB_ADDR  <= rd_oor ? 13'd0 : rd_addr_q;
        rd_oor_q <= rd_oor;
        rd_pend  <= 1'b0;
        if (rd_oor) WR_ERR <= 1'b1;
      end
`endif
      else begin
        state <= IDLE;
        FB_WE <= 1'b0;
      end
`ifdef FB_READBACK_EN
      if (CPU_RD_VALID && !rd_pend) begin
        rd_pend   <= 1'b1;
        rd_addr_q <= CPU_RD_ADDR;
      end
`endif
    end
  end

  // fetch data arrives the cycle after VFETCH; present it at the cell boundary
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_d    <= 1'b0;
      CELL_INDEX <= '0;
      CELL_VALID <= 1'b0;
    end else begin
      fetch_d <= (state == VFETCH);
      if (load_pt) begin
        CELL_VALID <= fetch_d;
        CELL_INDEX <= fetch_d ? FB_RDATA : 2'd0;
      end
    end
  end

`ifdef FB_READBACK_EN
  // read data lands two cycles after CREAD, with a one-cycle done pulse
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_d        <= 1'b0;
      CPU_RD_DONE <= 1'b0;
      CPU_RD_DATA <= '0;
    end else begin
      rd_d        <= (state == CREAD);
      CPU_RD_DONE <= rd_d;
      if (rd_d) CPU_RD_DATA <= rd_oor_q ? 2'd0 : FB_RDATA;
    end
  end
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: directed phases with random CPU traffic, checked every cycle
// against a queue-based reference of the arbitration rules.
module tb_fb_arbiter;
  localparam int COLS = 100, ROWS = 75, H_TOTAL = 1040, V_TOTAL = 666;
  localparam int FIFO_DEPTH = 4, CELLS = COLS * ROWS;

  logic clk = 1'b0;
  logic rst_n;
  logic [10:0] px, py;
  logic on_screen;
  logic wr_valid, wr_ready;
  logic [12:0] wr_addr;
  logic [1:0] wr_data;
  logic [12:0] fb_addr;
  logic fb_we;
  logic [1:0] fb_wdata, fb_rdata, cell_index;
  logic cell_valid, wr_err;
`ifdef FB_READBACK_EN
  logic rd_valid, rd_done;
  logic [12:0] rd_addr;
  logic [1:0] rd_data;
`endif

  always #5 clk = ~clk;

  fb_arbiter #(.COLS(COLS), .ROWS(ROWS), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
               .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK_PIXEL(clk), .RESET_N(rst_n), .PIXEL_X(px), .PIXEL_Y(py),
    .ON_SCREEN(on_screen), .CPU_WR_VALID(wr_valid), .CPU_WR_READY(wr_ready),
    .CPU_WR_ADDR(wr_addr), .CPU_WR_DATA(wr_data), .FB_ADDR(fb_addr),
    .FB_WE(fb_we), .FB_WDATA(fb_wdata), .FB_RDATA(fb_rdata),
    .CELL_INDEX(cell_index), .CELL_VALID(cell_valid), .WR_ERR(wr_err)
`ifdef FB_READBACK_EN
    , .CPU_RD_VALID(rd_valid), .CPU_RD_ADDR(rd_addr), .CPU_RD_DATA(rd_data),
    .CPU_RD_DONE(rd_done)
`endif
  );

  function automatic logic [1:0] init_val(int i);
    return 2'((i * 7 + 3) % 4);
  endfunction

  // framebuffer memory: registered read, one cycle after the address
  logic [1:0] mem [CELLS];
  logic mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (fb_we && fb_addr < 13'(CELLS)) begin
      mem[fb_addr] <= fb_wdata;
    end
    fb_rdata <= (fb_addr < 13'(CELLS)) ? mem[fb_addr] : 2'd0;
  end

  // ---------------- reference model ----------------
  logic [14:0] wq[$];
  logic [1:0]  ref_mem [CELLS];
  bit          m_ready, m_err, e_we, e_cv, grp_fetch;
  logic [12:0] e_addr;
  logic [1:0]  e_wdata, e_ci, grp_val;
  int x, y, cyc_no, last_we5, n_checks, n_err, n_push;
  int we_log[$];
  bit chk_addr = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d x=%0d y=%0d)", tag, obs, exp, cyc_no, x, y);
    end
  endtask

  task automatic model_reset();
    wq.delete();
    m_ready = 0; m_err = 0; e_we = 0; e_addr = '0; e_wdata = '0;
    e_ci = '0; e_cv = 0; grp_fetch = 0; grp_val = '0;
  endtask

  // what the next clock edge must produce, from the rules on the current pixel
  task automatic model_edge();
    bit pre_ready, slot;
    int nx, row, col;
    logic [14:0] h;
    pre_ready = m_ready && (wq.size() < FIFO_DEPTH);
    if (x % 8 == 7 || x == H_TOTAL - 1) begin
      e_cv = grp_fetch;
      e_ci = grp_fetch ? grp_val : 2'd0;
      grp_fetch = 0;
    end
    nx = (x + 1) % H_TOTAL; slot = 0; row = 0; col = 0;
    if (nx == H_TOTAL - 2) begin
      slot = 1; row = ((y + 1) % V_TOTAL) / 8; col = 0;
    end else if (nx % 8 == 6 && (nx + 2) / 8 < COLS) begin
      slot = 1; row = y / 8; col = (nx + 2) / 8;
    end
    if (slot && row < ROWS) begin
      e_we = 0; e_addr = 13'(row * COLS + col);
      grp_fetch = 1; grp_val = ref_mem[row * COLS + col];
    end else if (wq.size() > 0) begin
      h = wq.pop_front();
      e_we = 1; e_addr = h[14:2]; e_wdata = h[1:0];
      ref_mem[int'(h[14:2])] = h[1:0];
    end else begin
      e_we = 0;
    end
    if (wr_valid && pre_ready) begin
      if (int'(wr_addr) >= CELLS) m_err = 1;
      else wq.push_back({wr_addr, wr_data});
    end
    m_ready = 1;
  endtask

  task automatic check_all();
    chk("fb_we", 32'(fb_we), 32'(e_we));
    if (chk_addr) chk("fb_addr", 32'(fb_addr), 32'(e_addr));
    chk("fb_wdata", 32'(fb_wdata), 32'(e_wdata));
    chk("cell_index", 32'(cell_index), 32'(e_ci));
    chk("cell_valid", 32'(cell_valid), 32'(e_cv));
    chk("wr_ready", 32'(wr_ready), 32'(m_ready && (wq.size() < FIFO_DEPTH)));
    chk("wr_err", 32'(wr_err), 32'(m_err));
  endtask

  task automatic drive_pix();
    px = 11'(x); py = 11'(y);
    on_screen = (x < COLS * 8) && (y < ROWS * 8);
  endtask

  task automatic tick();
    if (rst_n) model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc_no++;
    x++;
    if (x == H_TOTAL) begin x = 0; y = (y + 1) % V_TOTAL; end
    drive_pix();
    check_all();
    if (fb_we) begin
      we_log.push_back(int'(fb_addr));
      if (fb_addr == 13'd5) last_we5 = cyc_no;
    end
  endtask

  task automatic rand_cyc(input bit allow_oor);
    wr_valid = ($urandom_range(0, 2) == 0);
    if (allow_oor && $urandom_range(0, 19) == 0) wr_addr = 13'($urandom_range(CELLS, 8191));
    else wr_addr = 13'($urandom_range(0, CELLS - 1));
    wr_data = 2'($urandom_range(0, 3));
    tick();
  endtask

  // hold a write until the DUT takes it, bounded
  task automatic push(input logic [12:0] a, input logic [1:0] d);
    bit done;
    done = 0;
    wr_valid = 1; wr_addr = a; wr_data = d;
    for (int k = 0; k < 20 && !done; k++) begin
      done = wr_ready;
      tick();
    end
    wr_valid = 0;
    chk("push_accept", 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < CELLS; i++) ref_mem[i] = init_val(i);
    n_checks = 0; n_err = 0; cyc_no = 0; last_we5 = -1; n_push = 0;
    wr_valid = 0; wr_addr = '0; wr_data = '0;
`ifdef FB_READBACK_EN
    rd_valid = 0; rd_addr = '0;
`endif
    x = H_TOTAL - 4; y = 7; drive_pix();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (4) tick();              // now at x=0, y=8
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(wr_ready), 32'd0);

    // cell 101 holds 2: row 1 shows it for pixels 8..15
    for (int i = 0; i < 16; i++) begin
      tick();
      if (x >= 8 && x <= 15) begin
        chk("sweep_index", 32'(cell_index), 32'd2);
        chk("sweep_valid", 32'(cell_valid), 32'd1);
      end else if (x < 8) begin
        chk("sweep_blank", 32'(cell_valid), 32'd0);
      end
    end

    while (!(y == 9 && x == 0)) rand_cyc(0);
    wr_valid = 0;
    repeat (4) tick();

    // continuous CPU traffic across the first 64 pixels of a line
    we_log.delete(); n_push = 0;
    while (x < 64) begin
      wr_valid = 1;
      wr_addr = 13'($urandom_range(0, CELLS - 1));
      wr_data = 2'($urandom_range(0, 3));
      if (wr_ready) n_push++;
      tick();
      if (x % 8 == 6 && x < 64) chk("no_we_in_slot", 32'(fb_we), 32'd0);
    end
    wr_valid = 0;
    repeat (6) tick();
    chk("all_writes_land", 32'(we_log.size()), 32'(n_push));

    // five back-to-back writes in horizontal blank drain in order
    while (x != 796) rand_cyc(0);
    wr_valid = 0;
    repeat (4) tick();
    we_log.delete();
    for (int i = 0; i < 5; i++) push(13'(i), 2'($urandom_range(0, 3)));
    repeat (10) tick();
    chk("we_count", 32'(we_log.size()), 32'd5);
    for (int i = 0; i < we_log.size(); i++) chk("we_order", 32'(we_log[i]), 32'(i));

    // out-of-range write: no strobe, sticky error
    we_log.delete();
    push(13'd7500, 2'd1);
    repeat (5) tick();
    chk("oor_no_we", 32'(we_log.size()), 32'd0);
    chk("wr_err_set", 32'(wr_err), 32'd1);
    repeat (60) rand_cyc(0);
    chk("wr_err_sticky", 32'(wr_err), 32'd1);

    // reset with writes in flight: entries lost, error cleared
    while (x % 8 != 1) rand_cyc(0);
    wr_valid = 0;
    push(13'd40, 2'd1); push(13'd41, 2'd2); push(13'd42, 2'd3);
    rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_we", 32'(fb_we), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    we_log.delete();
    tick();
    chk("ready_after_release", 32'(wr_ready), 32'd1);
    repeat (20) tick();
    chk("lost_entries", 32'(we_log.size()), 32'd0);

    // long random run including out-of-range writes
    repeat (3000) rand_cyc(1);
    wr_valid = 0;
    repeat (8) tick();

`ifdef FB_READBACK_EN
    begin
      bit got;
      int got_cyc;
      logic [1:0] got_data;
      chk_addr = 0;
      got = 0; got_cyc = 0; got_data = '0;
      push(13'd5, 2'd3);
      rd_valid = 1; rd_addr = 13'd5;
      tick();
      rd_valid = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        if (rd_done) begin got = 1; got_data = rd_data; got_cyc = cyc_no; end
        else tick();
      end
      chk("rd_done", 32'(got), 32'd1);
      chk("rd_data", 32'(got_data), 32'd3);
      chk("rd_after_we", 32'(got_cyc > last_we5 && last_we5 >= 0), 32'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
